sprite_palette_encoder: RTL and testbench

SPRITE_PALETTE_ENCODER -- requirements
Module: sprite_palette_encoder

---
 rtl/sprite_palette_encoder.sv | 111 +++++++++++
 tb/tb_sprite_palette_encoder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_palette_encoder.sv
// Converts an RGB888 pixel stream into palette indices and writes them to image RAM.
// One write per accepted pixel, one cycle after the transfer; the frame ends after WIDTH*HEIGHT pixels.
module sprite_palette_encoder #(
   parameter int WIDTH       = 16,
   parameter int HEIGHT      = 64,
   parameter int PAL_ENTRIES = 16,
   localparam int AW         = $clog2(WIDTH * HEIGHT),
   localparam int PW         = $clog2(PAL_ENTRIES)
) (
   input  logic          pixel_clk_in,
   input  logic          rst_n_in,
   input  logic          start_in,
   input  logic          pal_we_in,
   input  logic [PW-1:0] pal_addr_in,
   input  logic [23:0]   pal_data_in,
   input  logic          pix_valid_in,
   input  logic [23:0]   pix_rgb_in,
   output logic          pix_ready_out,
   output logic          ram_we_out,
   output logic [AW-1:0] ram_addr_out,
   output logic [7:0]    ram_data_out,
   output logic          busy_out,
   output logic          done_out,
   output logic          miss_out
);

   localparam logic [0:0]    IDLE = 1'b0;
   localparam logic [0:0]    RUN  = 1'b1;
   localparam logic [AW-1:0] LAST = AW'(WIDTH * HEIGHT - 1);

   logic [0:0]    r_state;
   logic [AW-1:0] r_count;
   logic [23:0]   r_pal [PAL_ENTRIES];
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [7:0]    r_data;
   logic          r_done;
   logic          r_miss;
   logic [7:0]    w_idx;
   logic          w_hit;
   logic          w_xfer;

   assign w_xfer        = (r_state == RUN) && pix_valid_in;
   assign pix_ready_out = (r_state == RUN);
   assign busy_out      = (r_state == RUN);
   assign ram_we_out    = r_we;
   assign ram_addr_out  = r_addr;
   assign ram_data_out  = r_data;
   assign done_out      = r_done;
   assign miss_out      = r_miss;

   // Scan from the top so the lowest matching entry wins.
   always_comb begin
      w_idx = '0;
      w_hit = 1'b0;
      for (int i = PAL_ENTRIES - 1; i >= 0; i--) begin
         if (r_pal[i] == pix_rgb_in) begin
            w_idx = 8'(i);
            w_hit = 1'b1;
         end
      end
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < PAL_ENTRIES; i++) r_pal[i] <= '0;
      end else if (pal_we_in && (int'(pal_addr_in) < PAL_ENTRIES)) begin
         r_pal[pal_addr_in] <= pal_data_in;
      end
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= IDLE;
         r_count <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_done  <= 1'b0;
         r_miss  <= 1'b0;
      end else begin
         r_we   <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start_in) begin
                  r_state <= RUN;
                  r_count <= '0;
                  r_miss  <= 1'b0;
               end
            end
            default: begin
               if (w_xfer) begin
                  r_we   <= 1'b1;
                  r_addr <= r_count;
                  r_data <= w_idx;
                  if (!w_hit) r_miss <= 1'b1;
                  // Counter parks on the last address; only a new start rewinds it.
                  if (r_count == LAST) begin
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_count <= r_count + 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_palette_encoder.sv
// Directed bench for sprite_palette_encoder: a per-cycle vector table plus
// hand-written full-frame, miss, palette-priority and mid-frame reset sequences.
module tb_sprite_palette_encoder;

   localparam int NPIX = 1024;

   logic        clk = 1'b0;
   logic        rstN;
   logic        start;
   logic        palWe;
   logic [3:0]  palAddr;
   logic [23:0] palData;
   logic        pixValid;
   logic [23:0] pixRgb;
   logic        pixReady;
   logic        ramWe;
   logic [9:0]  ramAddr;
   logic [7:0]  ramData;
   logic        busy;
   logic        done;
   logic        miss;

   int total = 0;
   int bad   = 0;

   logic [23:0] colours [4] = '{24'h000000, 24'hFFD700, 24'hB8860B, 24'hFFFFFF};

   typedef struct {
      bit          start;
      bit          palWe;
      logic [3:0]  palAddr;
      logic [23:0] palData;
      bit          valid;
      logic [23:0] rgb;
      bit          expReady;
      bit          expWe;
      logic [9:0]  expAddr;
      logic [7:0]  expData;
      bit          expBusy;
      bit          expDone;
      bit          expMiss;
   } vec_t;

   vec_t vecs [14];

   sprite_palette_encoder dut (
      .pixel_clk_in (clk),
      .rst_n_in     (rstN),
      .start_in     (start),
      .pal_we_in    (palWe),
      .pal_addr_in  (palAddr),
      .pal_data_in  (palData),
      .pix_valid_in (pixValid),
      .pix_rgb_in   (pixRgb),
      .pix_ready_out(pixReady),
      .ram_we_out   (ramWe),
      .ram_addr_out (ramAddr),
      .ram_data_out (ramData),
      .busy_out     (busy),
      .done_out     (done),
      .miss_out     (miss)
   );

   // Free-running pixel clock, 10 time units per period.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%h want=%h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      start    = 1'b0;
      palWe    = 1'b0;
      palAddr  = '0;
      palData  = '0;
      pixValid = 1'b0;
      pixRgb   = '0;
   endtask

   task automatic applyStimulus(input vec_t v);
      start    = v.start;
      palWe    = v.palWe;
      palAddr  = v.palAddr;
      palData  = v.palData;
      pixValid = v.valid;
      pixRgb   = v.rgb;
      stepClock();
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ready"}, 32'(pixReady), 0);
      checkOutput({tag, "_we"},    32'(ramWe),    0);
      checkOutput({tag, "_addr"},  32'(ramAddr),  0);
      checkOutput({tag, "_data"},  32'(ramData),  0);
      checkOutput({tag, "_busy"},  32'(busy),     0);
      checkOutput({tag, "_done"},  32'(done),     0);
      checkOutput({tag, "_miss"},  32'(miss),     0);
   endtask

   task automatic doReset();
      idleInputs();
      rstN = 1'b0;
      stepClock();
      stepClock();
      @(negedge clk);
      rstN = 1'b1;
      stepClock();
   endtask

   task automatic loadPalette();
      for (int i = 0; i < 4; i++) begin
         palWe   = 1'b1;
         palAddr = 4'(i);
         palData = colours[i];
         stepClock();
      end
      palWe = 1'b0;
   endtask

   task automatic startFrame(input string tag);
      start = 1'b1;
      stepClock();
      start = 1'b0;
      checkOutput({tag, "_start_busy"},  32'(busy),     1);
      checkOutput({tag, "_start_ready"}, 32'(pixReady), 1);
      checkOutput({tag, "_start_miss"},  32'(miss),     0);
   endtask

   // Streams pixels 0..nPix-1 with colours cycling; pixel missAt carries an unlisted colour.
   task automatic streamRun(input string tag, input int nPix, input bit toggle, input int missAt);
      int k = 0;
      int c = 0;
      int doneSeen = 0;
      while (k < nPix && c < 4 * NPIX) begin
         pixValid = toggle ? ((c % 2) == 0) : 1'b1;
         pixRgb   = (k == missAt) ? 24'h123456 : colours[k % 4];
         stepClock();
         if (done) doneSeen++;
         if (pixValid) begin
            checkOutput({tag, "_we"},   32'(ramWe),   1);
            checkOutput({tag, "_addr"}, 32'(ramAddr), 32'(k));
            checkOutput({tag, "_data"}, 32'(ramData), (k == missAt) ? 0 : 32'(k % 4));
            checkOutput({tag, "_done"}, 32'(done),    (k == NPIX - 1) ? 1 : 0);
            checkOutput({tag, "_busy"}, 32'(busy),    (k == NPIX - 1) ? 0 : 1);
            k++;
         end else begin
            checkOutput({tag, "_gap_we"},   32'(ramWe),   0);
            checkOutput({tag, "_gap_addr"}, 32'(ramAddr), 32'(k - 1));
         end
         c++;
      end
      pixValid = 1'b0;
      checkOutput({tag, "_count"}, 32'(k), 32'(nPix));
      checkOutput({tag, "_done_pulses"}, 32'(doneSeen), (nPix == NPIX) ? 1 : 0);
   endtask

   task automatic checkIdleAfterFrame(input string tag, input bit expMiss);
      pixValid = 1'b1;
      pixRgb   = colours[1];
      stepClock();
      checkOutput({tag, "_post_we"},    32'(ramWe),    0);
      checkOutput({tag, "_post_ready"}, 32'(pixReady), 0);
      checkOutput({tag, "_post_busy"},  32'(busy),     0);
      checkOutput({tag, "_post_done"},  32'(done),     0);
      checkOutput({tag, "_post_miss"},  32'(miss),     32'(expMiss));
      pixValid = 1'b0;
   endtask

   initial begin
      //           st  pwe paddr pdata        vld rgb          rdy we addr   data  bsy dn  miss
      vecs[0]  = '{0, 1, 4'd0, 24'h000000, 0, 24'h000000, 0, 0, 10'd0, 8'd0, 0, 0, 0};
      vecs[1]  = '{0, 1, 4'd1, 24'hFFD700, 0, 24'h000000, 0, 0, 10'd0, 8'd0, 0, 0, 0};
      vecs[2]  = '{0, 1, 4'd2, 24'hB8860B, 0, 24'h000000, 0, 0, 10'd0, 8'd0, 0, 0, 0};
      vecs[3]  = '{0, 1, 4'd3, 24'hFFFFFF, 1, 24'hFFD700, 0, 0, 10'd0, 8'd0, 0, 0, 0};
      vecs[4]  = '{1, 0, 4'd0, 24'h000000, 1, 24'hFFD700, 1, 0, 10'd0, 8'd0, 1, 0, 0};
      vecs[5]  = '{0, 0, 4'd0, 24'h000000, 1, 24'h000000, 1, 1, 10'd0, 8'd0, 1, 0, 0};
      vecs[6]  = '{0, 0, 4'd0, 24'h000000, 0, 24'hFFFFFF, 1, 0, 10'd0, 8'd0, 1, 0, 0};
      vecs[7]  = '{0, 0, 4'd0, 24'h000000, 1, 24'hFFD700, 1, 1, 10'd1, 8'd1, 1, 0, 0};
      vecs[8]  = '{1, 0, 4'd0, 24'h000000, 1, 24'hB8860B, 1, 1, 10'd2, 8'd2, 1, 0, 0};
      vecs[9]  = '{0, 0, 4'd0, 24'h000000, 1, 24'h123456, 1, 1, 10'd3, 8'd0, 1, 0, 1};
      vecs[10] = '{0, 0, 4'd0, 24'h000000, 1, 24'hFFFFFF, 1, 1, 10'd4, 8'd3, 1, 0, 1};
      vecs[11] = '{0, 0, 4'd0, 24'h000000, 0, 24'h000000, 1, 0, 10'd4, 8'd3, 1, 0, 1};
      vecs[12] = '{0, 1, 4'd2, 24'h010101, 1, 24'hB8860B, 1, 1, 10'd5, 8'd2, 1, 0, 1};
      vecs[13] = '{0, 0, 4'd0, 24'h000000, 1, 24'hB8860B, 1, 1, 10'd6, 8'd0, 1, 0, 1};

      idleInputs();
      rstN = 1'b0;
      #2;
      checkAllZero("reset");
      stepClock();
      checkAllZero("reset_clk");
      @(negedge clk);
      rstN = 1'b1;
      stepClock();

      for (int i = 0; i < 14; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d_ready", i), 32'(pixReady), 32'(vecs[i].expReady));
         checkOutput($sformatf("vec%0d_we", i),    32'(ramWe),    32'(vecs[i].expWe));
         checkOutput($sformatf("vec%0d_addr", i),  32'(ramAddr),  32'(vecs[i].expAddr));
         checkOutput($sformatf("vec%0d_data", i),  32'(ramData),  32'(vecs[i].expData));
         checkOutput($sformatf("vec%0d_busy", i),  32'(busy),     32'(vecs[i].expBusy));
         checkOutput($sformatf("vec%0d_done", i),  32'(done),     32'(vecs[i].expDone));
         checkOutput($sformatf("vec%0d_miss", i),  32'(miss),     32'(vecs[i].expMiss));
      end
      idleInputs();

      // Full frame, valid held high.
      doReset();
      loadPalette();
      startFrame("full");
      streamRun("full", NPIX, 1'b0, -1);
      checkIdleAfterFrame("full", 1'b0);

      // Full frame, valid every other cycle.
      startFrame("toggle");
      streamRun("toggle", NPIX, 1'b1, -1);
      checkIdleAfterFrame("toggle", 1'b0);

      // Unlisted colour at address 5; miss sticks until the next start.
      startFrame("miss");
      streamRun("miss", NPIX, 1'b0, 5);
      checkIdleAfterFrame("miss", 1'b1);
      stepClock();
      checkOutput("miss_held", 32'(miss), 1);
      startFrame("miss_clear");

      // Duplicate entries and same-cycle palette write.
      doReset();
      palWe = 1'b1; palAddr = 4'd2; palData = 24'hFFD700; stepClock();
      palAddr = 4'd7; stepClock();
      palWe = 1'b0;
      startFrame("prio");
      pixValid = 1'b1; pixRgb = 24'hFFD700; stepClock();
      checkOutput("prio_first_addr", 32'(ramAddr), 0);
      checkOutput("prio_first_data", 32'(ramData), 2);
      palWe = 1'b1; palAddr = 4'd2; palData = 24'h010101; stepClock();
      palWe = 1'b0;
      checkOutput("prio_samecyc_we",   32'(ramWe),   1);
      checkOutput("prio_samecyc_data", 32'(ramData), 2);
      stepClock();
      checkOutput("prio_after_addr", 32'(ramAddr), 2);
      checkOutput("prio_after_data", 32'(ramData), 7);
      checkOutput("prio_after_miss", 32'(miss),    0);
      pixValid = 1'b0;

      // Mid-frame reset after 300 transfers.
      doReset();
      loadPalette();
      startFrame("abort");
      streamRun("abort", 300, 1'b0, -1);
      pixValid = 1'b1;
      pixRgb   = colours[0];
      rstN     = 1'b0;
      #1;
      checkAllZero("abort_async");
      stepClock();
      checkAllZero("abort_edge");
      @(negedge clk);
      rstN = 1'b1;
      stepClock();
      checkOutput("abort_idle_ready", 32'(pixReady), 0);
      checkOutput("abort_idle_we",    32'(ramWe),    0);
      stepClock();
      checkOutput("abort_idle_we2",   32'(ramWe),    0);
      pixValid = 1'b0;
      startFrame("restart");
      pixValid = 1'b1; pixRgb = 24'hFFD700; stepClock();
      checkOutput("restart_addr0", 32'(ramAddr), 0);
      checkOutput("restart_data0", 32'(ramData), 0);
      checkOutput("restart_miss",  32'(miss),    1);
      pixRgb = 24'h000000; stepClock();
      checkOutput("restart_addr1", 32'(ramAddr), 1);
      checkOutput("restart_data1", 32'(ramData), 0);
      idleInputs();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
